// File: rtl/xa_bf_beam_sched.sv
// Beam scheduler: steps through the direction table once per frame and hands each beam to the delay block.
// Optional watchdog in RUN is enabled by defining XA_BF_SCHED_WDT_EN.
module xa_bf_beam_sched #(
  parameter logic [10:0] P_stave_num = 11'd250,
  parameter logic [8:0]  P_beam_max  = 9'd256,
  parameter logic [7:0]  P_guard_clk = 8'd232,
  parameter logic [15:0] P_wdt_clk   = 16'd1024
) (
  input  logic        i_arst,
  input  logic        i_clk156m,
  input  logic        i_frame_start,
  input  logic        i_abort,
  input  logic [8:0]  i_beam_num,
  input  logic        i_dir_wr_en,
  input  logic [31:0] i_dir_wr_data,
  input  logic        i_ds_ready,
  input  logic        i_ch_start0,
  input  logic        i_ch_start1,
  output logic        o_bm_start,
  output logic [31:0] o_bf_dir_vector_ss_x,
  output logic [31:0] o_bf_dir_vector_ss_y,
  output logic [31:0] o_bf_dir_vector_ss_z,
  output logic [7:0]  o_beam_idx,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_err_overrun,
  output logic        o_err_wdt
);

  localparam logic [10:0] N0 = ((P_stave_num - 11'd1) >> 1) + 11'd1;
  localparam logic [10:0] N1 = P_stave_num - (P_stave_num >> 1);
  localparam int unsigned DEPTH = 3 * int'(P_beam_max);
  localparam logic [9:0]  DEPTH_A = 10'(DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_RDY, START, RUN, GUARD, NEXT, DONE} state_t;

  state_t      state_q, state_d;
  logic [8:0]  num_q, num_d;
  logic [7:0]  idx_q, idx_d;
  logic [1:0]  lcnt_q, lcnt_d;
  logic [10:0] c0_q, c0_d, c1_q, c1_d, c0_inc, c1_inc;
  logic [7:0]  gcnt_q, gcnt_d;
  logic [9:0]  wa_q;
  logic [31:0] rd_q, xt_q, yt_q, vx_q, vy_q, vz_q;
  logic [7:0]  bidx_q;
  logic        ovr_q;
  logic        wdt_fire;
  logic [1:0]  rd_off;
  logic [9:0]  rd_addr;
  logic [8:0]  num_clamp;
  logic        wr_ok;

  logic [31:0] tbl [DEPTH];

  assign wr_ok     = i_dir_wr_en && (state_q == IDLE) && (wa_q < DEPTH_A);
  assign rd_off    = (lcnt_q == 2'd3) ? 2'd2 : lcnt_q;
  assign rd_addr   = ({2'b00, idx_q} * 10'd3) + {8'b0, rd_off};
  assign num_clamp = (i_beam_num > P_beam_max) ? P_beam_max : i_beam_num;
  assign c0_inc    = c0_q + {10'b0, (i_ch_start0 && (c0_q < N0))};
  assign c1_inc    = c1_q + {10'b0, (i_ch_start1 && (c1_q < N1))};

  // Table storage is deliberately left out of reset.
  always_ff @(posedge i_clk156m) begin
    if (wr_ok) tbl[wa_q] <= i_dir_wr_data;
    rd_q <= tbl[rd_addr];
  end

`ifdef XA_BF_SCHED_WDT_EN
  logic [15:0] wdt_q;
  // Counts cycles since the last channel start; START counts as the clearing cycle.
  always_ff @(posedge i_clk156m or posedge i_arst) begin
    if (i_arst)                 wdt_q <= 16'd0;
    else if (state_q == START)  wdt_q <= 16'd1;
    else if (state_q == RUN)    wdt_q <= (i_ch_start0 || i_ch_start1) ? 16'd1 : wdt_q + 16'd1;
  end
  assign wdt_fire = (state_q == RUN) && (wdt_q == P_wdt_clk);
`else
  assign wdt_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    idx_d   = idx_q;
    lcnt_d  = lcnt_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      IDLE: if (i_frame_start && !i_abort) begin
        num_d   = num_clamp;
        idx_d   = 8'd0;
        lcnt_d  = 2'd0;
        state_d = (num_clamp == 9'd0) ? DONE : LOAD;
      end
      LOAD: begin
        lcnt_d = lcnt_q + 2'd1;
        if (lcnt_q == 2'd3) state_d = WAIT_RDY;
      end
      WAIT_RDY: if (i_ds_ready) state_d = START;
      START: begin
        c0_d    = 11'd0;
        c1_d    = 11'd0;
        state_d = RUN;
      end
      RUN: begin
        c0_d = c0_inc;
        c1_d = c1_inc;
        if ((c0_inc == N0) && (c1_inc == N1)) begin
          gcnt_d  = 8'd0;
          state_d = GUARD;
        end
      end
      GUARD: begin
        gcnt_d = gcnt_q + 8'd1;
        if (gcnt_q == P_guard_clk - 8'd1) state_d = NEXT;
      end
      NEXT: if ({1'b0, idx_q} == num_q - 9'd1) state_d = DONE;
        else begin
          idx_d   = idx_q + 8'd1;
          lcnt_d  = 2'd0;
          state_d = LOAD;
        end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (wdt_fire) state_d = IDLE;
    if (i_abort && (state_q != IDLE)) state_d = IDLE;
  end

  always_ff @(posedge i_clk156m or posedge i_arst) begin
    if (i_arst) begin
      state_q <= IDLE;
      num_q   <= 9'd0;
      idx_q   <= 8'd0;
      lcnt_q  <= 2'd0;
      c0_q    <= 11'd0;
      c1_q    <= 11'd0;
      gcnt_q  <= 8'd0;
      wa_q    <= 10'd0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      lcnt_q  <= lcnt_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      gcnt_q  <= gcnt_d;
      wa_q    <= i_dir_wr_en ? wa_q + 10'd1 : 10'd0;
      ovr_q   <= i_frame_start && (state_q != IDLE);
    end
  end

  // X and Y are staged so all three vector words and the index change on the same edge.
  always_ff @(posedge i_clk156m or posedge i_arst) begin
    if (i_arst) begin
      xt_q   <= 32'd0;
      yt_q   <= 32'd0;
      vx_q   <= 32'd0;
      vy_q   <= 32'd0;
      vz_q   <= 32'd0;
      bidx_q <= 8'd0;
    end else if (state_q == LOAD) begin
      case (lcnt_q)
        2'd1: xt_q <= rd_q;
        2'd2: yt_q <= rd_q;
        2'd3: begin
          vx_q   <= xt_q;
          vy_q   <= yt_q;
          vz_q   <= rd_q;
          bidx_q <= idx_q;
        end
        default: ;
      endcase
    end
  end

  assign o_bm_start           = (state_q == START);
  assign o_busy               = (state_q != IDLE);
  assign o_frame_done         = (state_q == DONE);
  assign o_err_overrun        = ovr_q;
  assign o_err_wdt            = wdt_fire;
  assign o_bf_dir_vector_ss_x = vx_q;
  assign o_bf_dir_vector_ss_y = vy_q;
  assign o_bf_dir_vector_ss_z = vz_q;
  assign o_beam_idx           = bidx_q;

endmodule

// File: tb/tb_xa_bf_beam_sched.sv
// Scoreboard bench for xa_bf_beam_sched: stimulus pushes expected beams/events, a monitor pops and compares.
module tb_xa_bf_beam_sched;
  logic        clk = 1'b0;
  logic        arst, frame_start, abort_i, wr_en, ds_ready, ch0, ch1;
  logic [8:0]  beam_num;
  logic [31:0] wr_data;
  logic        bm_start, busy, frame_done, err_ovr, err_wdt;
  logic [31:0] vx, vy, vz;
  logic [7:0]  bidx;

  always #3 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  xa_bf_beam_sched dut (
    .i_arst(arst), .i_clk156m(clk), .i_frame_start(frame_start), .i_abort(abort_i),
    .i_beam_num(beam_num), .i_dir_wr_en(wr_en), .i_dir_wr_data(wr_data),
    .i_ds_ready(ds_ready), .i_ch_start0(ch0), .i_ch_start1(ch1),
    .o_bm_start(bm_start), .o_bf_dir_vector_ss_x(vx), .o_bf_dir_vector_ss_y(vy),
    .o_bf_dir_vector_ss_z(vz), .o_beam_idx(bidx), .o_busy(busy),
    .o_frame_done(frame_done), .o_err_overrun(err_ovr), .o_err_wdt(err_wdt));

  typedef struct { int idx; logic [31:0] x, y, z; } bm_t;
  bm_t  exp_bm[$];
  int   exp_done_q[$], exp_ovr_q[$], exp_wdt_q[$];
  logic [31:0] tbl [768];
  logic [31:0] wq[$];
  int   n_chk = 0, n_fail = 0;
  int   bm_cnt = 0;
  int   drv_limit = 0, drv_last1 = 0, drv_last_any = 0, drv_beams_done = 0;
  bit   drv_kill = 0, drv_active = 0;
  bit   rdy_pend = 0, rdy_rand = 0;
  int   rdy_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    n_chk++; n_fail++;
    $display("FAIL %s: event seen, none expected (cycle %0d)", nm, cyc);
  endtask

  // Channel-start generator: 125 counted pulses per lane in random order, plus surplus pulses.
  initial begin : drv
    int r0, r1, sent;
    bit a, b, stable;
    logic [31:0] cx, cy, cz;
    r0 = 0; r1 = 0; sent = 0; stable = 1; cx = 0; cy = 0; cz = 0;
    forever begin
      @(negedge clk);
      ch0 = 1'b0; ch1 = 1'b0;
      if (drv_kill) drv_active = 0;
      else if (bm_start) begin
        drv_active = 1; r0 = 125; r1 = 125; sent = 0; stable = 1;
        cx = vx; cy = vy; cz = vz;
      end else if (drv_active) begin
        if (vx !== cx || vy !== cy || vz !== cz) stable = 0;
        if (drv_limit == 0 || sent < drv_limit) begin
          a = 1'($urandom % 2); b = 1'($urandom % 2);
          if (a && (r0 > 0 || r1 > 0)) begin ch0 = 1'b1; if (r0 > 0) r0--; end
          if (b && (r0 > 0 || r1 > 0)) begin
            ch1 = 1'b1;
            if (r1 > 0) begin r1--; if (r1 == 0) drv_last1 = cyc; end
          end
          if (ch0 || ch1) begin sent++; drv_last_any = cyc; end
          if (r0 == 0 && r1 == 0) begin
            drv_active = 0; drv_beams_done++;
            chk("vec_stable_in_run", {31'b0, stable}, 32'd1);
          end
        end
      end
    end
  end

  initial begin : mon
    bm_t e;
    int  c, d, da;
    forever begin
      @(negedge clk);
      if (bm_start) begin
        bm_cnt++;
        if (exp_bm.size() == 0) unexpected("bm_start");
        else begin
          e = exp_bm.pop_front();
          chk("beam_idx", {24'b0, bidx}, e.idx);
          chk("vec_x", vx, e.x);
          chk("vec_y", vy, e.y);
          chk("vec_z", vz, e.z);
          if (e.idx > 0) begin
            d = cyc - drv_last1; da = cyc - drv_last_any;
            chk("guard_gap", {31'b0, (d >= 232) && (rdy_rand || da <= 240)}, 32'd1);
          end
        end
        if (rdy_pend) begin chk("ready_latency", cyc - rdy_cyc, 1); rdy_pend = 0; end
      end
      if (frame_done) begin
        if (exp_done_q.size() == 0) unexpected("frame_done");
        else c = exp_done_q.pop_front();
      end
      if (err_ovr) begin
        if (exp_ovr_q.size() == 0) unexpected("err_overrun");
        else begin c = exp_ovr_q.pop_front(); chk("overrun_latency", cyc - c, 1); end
      end
      if (err_wdt) begin
        if (exp_wdt_q.size() == 0) unexpected("err_wdt");
        else begin c = exp_wdt_q.pop_front(); chk("wdt_latency", cyc - drv_last_any, 1024); end
      end
    end
  end

  task automatic push_frame(input int n);
    bm_t e;
    int nb;
    nb = (n > 256) ? 256 : n;
    for (int b = 0; b < nb; b++) begin
      e.idx = b; e.x = tbl[3*b]; e.y = tbl[3*b+1]; e.z = tbl[3*b+2];
      exp_bm.push_back(e);
    end
  endtask

  task automatic start_frame(input int n, input bit model);
    @(negedge clk);
    frame_start = 1'b1; beam_num = 9'(n);
    if (model) begin push_frame(n); exp_done_q.push_back(cyc); end
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wr_burst(input bit model);
    for (int i = 0; i < wq.size(); i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_data = wq[i];
      if (model && i < 768) tbl[i] = wq[i];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    int k;
    k = 0;
    rdy_rand = rnd;
    do begin
      @(negedge clk);
      if (rnd) ds_ready = 1'($urandom % 2);
      k++;
    end while (!(busy == 1'b0 && exp_bm.size() == 0 && exp_done_q.size() == 0) && k < budget);
    if (k >= budget) begin n_chk++; n_fail++; $display("FAIL wait_idle: timeout after %0d cycles", k); end
    ds_ready = 1'b1;
    rdy_rand = 0;
  endtask

  task automatic wait_active(input int budget);
    int k;
    k = 0;
    while (!drv_active && k < budget) begin @(negedge clk); k++; end
    if (k >= budget) begin n_chk++; n_fail++; $display("FAIL wait_run: timeout after %0d cycles", k); end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_bm_start", {31'b0, bm_start}, 0);
    chk("rst_vec_x", vx, 0);
    chk("rst_vec_y", vy, 0);
    chk("rst_vec_z", vz, 0);
    chk("rst_beam_idx", {24'b0, bidx}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_frame_done", {31'b0, frame_done}, 0);
    chk("rst_overrun", {31'b0, err_ovr}, 0);
    chk("rst_wdt", {31'b0, err_wdt}, 0);
  endtask

  initial begin : main
    int base, k, n;
    logic [7:0] sidx;
    arst = 1'b1; frame_start = 0; abort_i = 0; wr_en = 0; wr_data = 0;
    ds_ready = 1'b1; beam_num = 0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    arst = 1'b0;
    repeat (2) @(negedge clk);

    // two-beam frame from the reference table
    wq = '{32'h3F800000, 32'h0, 32'h0, 32'h0, 32'h3F800000, 32'h0};
    wr_burst(1);
    base = bm_cnt;
    start_frame(2, 1);
    wait_idle(5000, 0);
    chk("bm_count_2beam", bm_cnt - base, 2);

    // downstream not ready for 500 cycles
    ds_ready = 1'b0;
    base = bm_cnt;
    start_frame(1, 1);
    repeat (500) @(negedge clk);
    chk("no_bm_while_not_ready", bm_cnt - base, 0);
    ds_ready = 1'b1; rdy_cyc = cyc; rdy_pend = 1;
    wait_idle(5000, 0);
    chk("ready_seen", {31'b0, rdy_pend}, 0);

    // frame start while running; table writes while busy are dropped
    start_frame(2, 1);
    wait_active(100);
    repeat (10) @(negedge clk);
    sidx = bidx;
    frame_start = 1'b1; beam_num = 9'd5; exp_ovr_q.push_back(cyc);
    @(negedge clk);
    frame_start = 1'b0;
    chk("idx_after_overrun", {24'b0, bidx}, {24'b0, sidx});
    wq = '{$urandom, $urandom, $urandom};
    wr_burst(0);
    wait_idle(5000, 0);

    // zero-beam frame
    base = bm_cnt;
    start_frame(0, 1);
    wait_idle(100, 0);
    chk("bm_count_zero", bm_cnt - base, 0);

    // abort during guard
    k = drv_beams_done;
    start_frame(2, 1);
    n = 0;
    while (drv_beams_done == k && n < 2000) begin @(negedge clk); n++; end
    repeat (50) @(negedge clk);
    abort_i = 1'b1;
    exp_bm.delete(); exp_done_q.delete();
    @(negedge clk);
    abort_i = 1'b0;
    chk("busy_after_abort", {31'b0, busy}, 0);
    chk("vec_x_hold_abort", vx, tbl[0]);
    chk("vec_y_hold_abort", vy, tbl[1]);
    repeat (20) @(negedge clk);

    // abort wins over simultaneous frame start in IDLE
    base = bm_cnt;
    @(negedge clk);
    abort_i = 1'b1; frame_start = 1'b1; beam_num = 9'd2;
    @(negedge clk);
    abort_i = 1'b0; frame_start = 1'b0;
    repeat (20) @(negedge clk);
    chk("busy_abort_start", {31'b0, busy}, 0);
    chk("bm_count_abort_start", bm_cnt - base, 0);

    // full table plus three out-of-range words, then random frames with random ready
    wq.delete();
    for (int i = 0; i < 771; i++) wq.push_back($urandom);
    wr_burst(1);
    for (int f = 0; f < 3; f++) begin
      start_frame(int'($urandom_range(1, 3)), 1);
      wait_idle(8000, 1);
    end

    // reset while in RUN
    start_frame(2, 1);
    wait_active(100);
    repeat (20) @(negedge clk);
    arst = 1'b1; drv_kill = 1;
    #1;
    chk_reset_outputs();
    exp_bm.delete(); exp_done_q.delete();
    repeat (3) @(negedge clk);
    arst = 1'b0; drv_kill = 0;
    base = bm_cnt;
    start_frame(1, 1);
    wait_idle(5000, 0);
    chk("bm_count_after_reset", bm_cnt - base, 1);

`ifdef XA_BF_SCHED_WDT_EN
    drv_limit = 10;
    start_frame(1, 0);
    push_frame(1);
    exp_wdt_q.push_back(0);
    n = 0;
    while ((exp_wdt_q.size() != 0 || exp_bm.size() != 0) && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin n_chk++; n_fail++; $display("FAIL wdt_wait: timeout"); end
    @(negedge clk);
    chk("busy_after_wdt", {31'b0, busy}, 0);
    drv_kill = 1;
    repeat (3) @(negedge clk);
    drv_kill = 0; drv_limit = 0;
`endif

    repeat (10) @(negedge clk);
    chk("queues_empty", exp_bm.size() + exp_done_q.size() + exp_ovr_q.size() + exp_wdt_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : guard_timer
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
